// File: rtl/puneh_mem_sys.sv
// Puneh memory subsystem: word RAM plus a small memory-mapped I/O page
// (TX byte FIFO, latched RX byte, free-running cycle timer).
// Reads are combinational so the CPU can sample dataBus on the same edge
// that it asserts readMEM; all state changes happen on the rising clock edge.
module puneh_mem_sys #(
  parameter int    ADDR_W     = 12,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        readMEM,
  input  logic        writeMEM,
  input  logic [15:0] addrBus,
  input  logic [15:0] dataBus_out,
  output logic [15:0] dataBus,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid
);

  localparam int RAM_WORDS = 2 ** ADDR_W;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0] A_TXD  = 16'hFFF0;
  localparam logic [15:0] A_STAT = 16'hFFF1;
  localparam logic [15:0] A_RXD  = 16'hFFF2;
  localparam logic [15:0] A_TMR  = 16'hFFF3;

  // Status field only has room for 4 bits of occupancy; larger FIFOs clip at 15.
  function automatic logic [3:0] sat4(input logic [CNT_W-1:0] c);
    logic [31:0] w;
    w = 32'(c);
    if (w > 32'd15) return 4'hF;
    return w[3:0];
  endfunction

  // Storage arrays (data only, never reset)
  logic [15:0] ram_q  [RAM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  // Control / status registers
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             ovf_q,     ovf_d;
  logic             rx_full_q, rx_full_d;
  logic             rx_ovr_q,  rx_ovr_d;
  logic [7:0]       rx_buf_q,  rx_buf_d;
  logic [15:0]      timer_q,   timer_d;

  // Decode
  logic              ram_hit;
  logic              io_page;
  logic [ADDR_W-1:0] ram_idx;
  logic              ram_we;
  logic              txd_wr;
  logic              stat_wr;
  logic              tmr_wr;
  logic              rx_rd;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic [15:0]       rd_data;

  // Address decode and FIFO handshake terms
  always_comb begin
    ram_hit    = ((addrBus >> ADDR_W) == 16'd0);
    io_page    = (addrBus[15:2] == 14'h3FFC);
    ram_idx    = addrBus[ADDR_W-1:0];
    // A write presented while reset is high is discarded.
    ram_we     = writeMEM & ram_hit & ~io_page & ~rst;
    txd_wr     = writeMEM & (addrBus == A_TXD);
    stat_wr    = writeMEM & (addrBus == A_STAT);
    tmr_wr     = writeMEM & (addrBus == A_TMR);
    rx_rd      = readMEM  & (addrBus == A_RXD);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    pop        = ~fifo_empty & io_tx_ready;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    push       = txd_wr & (~fifo_full | pop) & ~rst;
  end

  // Combinational read mux; I/O page has priority over RAM
  always_comb begin
    rd_data = 16'h0000;
    if (addrBus == A_STAT)
      rd_data = {8'h00, sat4(count_q), ovf_q, rx_full_q, fifo_empty, fifo_full};
    else if (addrBus == A_RXD)
      rd_data = {7'b0, rx_ovr_q, rx_buf_q};
    else if (addrBus == A_TMR)
      rd_data = timer_q;
    else if (io_page)
      rd_data = 16'h0000;
    else if (ram_hit)
      rd_data = ram_q[ram_idx];
    dataBus = readMEM ? rd_data : 16'h0000;
  end

  // Head of FIFO is a direct array read, so it holds while the sink stalls
  always_comb begin
    io_tx_valid = ~fifo_empty;
    io_tx_data  = fifo_q[rd_ptr_q];
  end

  // Next-state logic for FIFO pointers, sticky flags, RX latch and timer
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    rx_full_d = rx_full_q;
    rx_ovr_d  = rx_ovr_q;
    rx_buf_d  = rx_buf_q;
    timer_d   = timer_q + 16'd1;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (stat_wr) begin
      ovf_d    = 1'b0;
      rx_ovr_d = 1'b0;
    end
    if (txd_wr & fifo_full & ~pop) ovf_d = 1'b1;

    // A new byte always wins; it only counts as an overrun if the old byte
    // was not being read out on this same edge.
    if (io_rx_valid) begin
      rx_buf_d  = io_rx_data;
      rx_full_d = 1'b1;
      if (rx_full_q & ~rx_rd) rx_ovr_d = 1'b1;
    end else if (rx_rd) begin
      rx_full_d = 1'b0;
    end

    if (tmr_wr) timer_d = dataBus_out;
  end

  // Control and status state, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rx_full_q <= 1'b0;
      rx_ovr_q  <= 1'b0;
      rx_buf_q  <= 8'h00;
      timer_q   <= 16'h0000;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rx_full_q <= rx_full_d;
      rx_ovr_q  <= rx_ovr_d;
      rx_buf_q  <= rx_buf_d;
      timer_q   <= timer_d;
    end
  end

  // Synchronous RAM write; new word visible to reads from the next cycle
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= dataBus_out;
  end

  // TX FIFO storage write
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= dataBus_out[7:0];
  end

endmodule
